// File: rtl/div_result_collector.sv
// rtl/div_result_collector.sv - captures divider results through a done/gotResult handshake into a FWFT FIFO
module div_result_collector #(
  parameter int DEPTH = 4,
  parameter int QW    = 10,
  parameter int RW    = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [QW-1:0]          Q,
  input  logic [QW:0]            A,
  input  logic                   done,
  input  logic                   divByZero,
  input  logic                   ov,
  output logic                   gotResult,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [QW-1:0]          res_quo,
  output logic [RW-1:0]          res_rem,
  output logic                   res_dbz,
  output logic                   res_ov,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = QW + RW + 2;

  typedef enum logic {IDLE, ACK} state_t;

  state_t        state, state_nxt;
  logic          push, pop;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [EW-1:0] wr_entry, head;
  logic          unused_a_hi;

  // The upper partial-remainder bits never carry part of the remainder.
  assign unused_a_hi = ^A[QW:RW];

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (done && !full) begin
          push      = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        if (!done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_entry = (divByZero || ov) ? {ov, divByZero, {(RW + QW){1'b0}}}
                                      : {ov, divByZero, A[RW-1:0], Q};
  assign pop      = res_valid && res_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gotResult <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      state     <= state_nxt;
      gotResult <= (state_nxt == ACK);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= wr_entry;
  end

  assign full      = (count == (AW + 1)'(DEPTH));
  assign empty     = (count == '0);
  assign res_valid = !empty;
  assign head      = empty ? '0 : mem[rd_ptr];
  assign res_quo   = head[QW-1:0];
  assign res_rem   = head[QW+RW-1:QW];
  assign res_dbz   = head[QW+RW];
  assign res_ov    = head[QW+RW+1];

endmodule

// File: tb/tb_div_result_collector.sv
// tb/tb_div_result_collector.sv - scoreboard bench for div_result_collector
module tb_div_result_collector;
  localparam int DEPTH = 4;
  localparam int QW    = 10;
  localparam int RW    = 5;
  localparam int EW    = QW + RW + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [QW-1:0] Q;
  logic [QW:0]   A;
  logic          done, divByZero, ov;
  logic          gotResult, res_valid, res_ready;
  logic [QW-1:0] res_quo;
  logic [RW-1:0] res_rem;
  logic          res_dbz, res_ov;
  logic [2:0]    count;
  logic          full, empty;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_exp, mon_got;
  int            total = 0;
  int            bad = 0;
  bit            rand_mode = 0;
  int            ready_pct = 50;
  logic          rnd_ready = 1'b0;
  logic          man_ready = 1'b0;

  div_result_collector #(.DEPTH(DEPTH), .QW(QW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .Q(Q), .A(A), .done(done), .divByZero(divByZero), .ov(ov),
    .gotResult(gotResult), .res_valid(res_valid), .res_ready(res_ready),
    .res_quo(res_quo), .res_rem(res_rem), .res_dbz(res_dbz), .res_ov(res_ov),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  assign res_ready = rand_mode ? rnd_ready : man_ready;

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 99) < ready_pct);
  end

  // Reference: one entry per done assertion, flags zero the payload, remainder is A mod 2^RW.
  function automatic logic [EW-1:0] model(int q, int a, bit dbz, bit ovf);
    int quo, rem;
    if (dbz || ovf) begin
      quo = 0;
      rem = 0;
    end else begin
      quo = q;
      rem = a % (1 << RW);
    end
    return {ovf, dbz, RW'(rem), QW'(quo)};
  endfunction

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      mon_got = {res_ov, res_dbz, res_rem, res_quo};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_entry: got %h but no entry expected", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          bad++;
          $display("FAIL pop_entry: got %h expected %h", mon_got, mon_exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic present(int q, int a, bit dbz, bit ovf);
    Q = QW'(q);
    A = (QW + 1)'(a);
    divByZero = dbz;
    ov = ovf;
    done = 1'b1;
    exp_q.push_back(model(q, a, dbz, ovf));
  endtask

  task automatic release_done();
    done = 1'b0;
    Q = QW'($urandom);
    A = (QW + 1)'($urandom);
    divByZero = 1'($urandom);
    ov = 1'($urandom);
  endtask

  task automatic issue(int q, int a, bit dbz, bit ovf, int hold);
    int n;
    present(q, a, dbz, ovf);
    n = 0;
    while (!gotResult && n < 300) begin
      step();
      n++;
    end
    chk("ack_seen", int'(gotResult), 1);
    repeat (hold) step();
    release_done();
    n = 0;
    while (gotResult && n < 50) begin
      step();
      n++;
    end
    chk("ack_release", int'(gotResult), 0);
  endtask

  task automatic drain();
    int n;
    man_ready = 1'b1;
    n = 0;
    while (!empty && n < 100) begin
      step();
      n++;
    end
    man_ready = 1'b0;
    chk("drained_empty", int'(empty), 1);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    done = 1'b0;
    Q = '0;
    A = '0;
    divByZero = 1'b0;
    ov = 1'b0;
    repeat (3) step();
    chk("rst_gotResult", int'(gotResult), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_valid", int'(res_valid), 0);
    chk("rst_fields", int'({res_ov, res_dbz, res_rem, res_quo}), 0);
    rst = 1'b0;
    step();

    // Long done pulse yields one entry; gotResult spans push+1 .. fall+1.
    present(38, 9, 0, 0);
    chk("t30_pre_ack", int'(gotResult), 0);
    step();
    chk("t30_ack_first", int'(gotResult), 1);
    chk("t30_count", int'(count), 1);
    repeat (4) begin
      step();
      chk("t30_ack_hold", int'(gotResult), 1);
    end
    release_done();
    chk("t30_ack_fall_cycle", int'(gotResult), 1);
    step();
    chk("t30_ack_dropped", int'(gotResult), 0);
    repeat (3) step();
    chk("t30_single_entry", int'(count), 1);
    chk("t30_head_quo", int'(res_quo), 38);
    chk("t30_head_rem", int'(res_rem), 9);
    drain();

    // Ordering and divide-by-zero zeroing.
    issue(13, 2, 0, 0, 0);
    issue(1023, 31, 1, 0, 0);
    chk("t31_head_quo", int'(res_quo), 13);
    chk("t31_head_rem", int'(res_rem), 2);
    man_ready = 1'b1;
    step();
    man_ready = 1'b0;
    chk("t31_head2", int'({res_ov, res_dbz, res_rem, res_quo}), int'(model(1023, 31, 1, 0)));
    chk("t31_head2_dbz", int'(res_dbz), 1);
    man_ready = 1'b1;
    step();
    man_ready = 1'b0;
    chk("t31_empty", int'(empty), 1);
    chk("t31_valid", int'(res_valid), 0);
    chk("t31_zero_fields", int'({res_ov, res_dbz, res_rem, res_quo}), 0);

    // Full backpressure: fifth result waits until a pop frees a slot.
    for (int i = 0; i < DEPTH; i++) issue(100 + i, 4 + i, 0, 0, 0);
    chk("t32_full", int'(full), 1);
    chk("t32_count4", int'(count), 4);
    present(555, 17, 0, 0);
    repeat (3) begin
      step();
      chk("t32_no_ack_when_full", int'(gotResult), 0);
      chk("t32_count_held", int'(count), 4);
    end
    man_ready = 1'b1;
    step();
    man_ready = 1'b0;
    chk("t32_after_pop_count", int'(count), 3);
    chk("t32_no_bypass", int'(gotResult), 0);
    step();
    chk("t32_captured_count", int'(count), 4);
    chk("t32_captured_ack", int'(gotResult), 1);
    release_done();
    step();
    drain();

    // Push and pop on the same edge.
    issue(200, 20, 0, 0, 0);
    issue(201, 21, 0, 0, 0);
    chk("t33_count2", int'(count), 2);
    present(202, 22, 0, 0);
    man_ready = 1'b1;
    step();
    man_ready = 1'b0;
    chk("t33_count_same", int'(count), 2);
    chk("t33_ack", int'(gotResult), 1);
    chk("t33_head_next", int'(res_quo), 201);
    release_done();
    step();
    drain();

    // Overflow zeroing.
    issue(5, 3, 0, 1, 1);
    chk("t35_head", int'({res_ov, res_dbz, res_rem, res_quo}), int'({1'b1, 1'b0, 15'd0}));
    drain();

    // Reset mid-handshake discards the entry; held done is captured again.
    present(77, 12, 0, 0);
    step();
    chk("t34_pre_count", int'(count), 1);
    chk("t34_pre_ack", int'(gotResult), 1);
    rst = 1'b1;
    man_ready = 1'b1;
    step();
    man_ready = 1'b0;
    exp_q.delete();
    exp_q.push_back(model(77, 12, 0, 0));
    chk("t34_rst_count", int'(count), 0);
    chk("t34_rst_ack", int'(gotResult), 0);
    chk("t34_rst_valid", int'(res_valid), 0);
    rst = 1'b0;
    step();
    chk("t34_recapture_count", int'(count), 1);
    chk("t34_recapture_ack", int'(gotResult), 1);
    release_done();
    step();
    drain();

    // Random traffic against the scoreboard, light then heavy backpressure.
    rand_mode = 1;
    for (int phase = 0; phase < 2; phase++) begin
      ready_pct = (phase == 0) ? 70 : 20;
      for (int i = 0; i < 40; i++) begin
        issue($urandom_range(0, 1023), $urandom_range(0, 2047),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
              $urandom_range(0, 3));
        repeat ($urandom_range(0, 2)) step();
      end
    end
    rand_mode = 0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
